id_hazard_ctrl: RTL and testbench
=================================

// Module: id_hazard_ctrl
// PURPOSE
//  Stall/flush controller feeding the ID-stage forwarding unit and the IF/ID, ID/EX pipe registers.
//  Detects hazards that forwarding cannot cover and holds the front end for a counted number of cycles:
//  - load-use
//  - branch/jalr in ID reading an EX ALU result or a pending load
//  Also flushes IF/ID on taken branch/jalr resolved in ID, and freezes everything on memory wait.
// PARAMETERS
//  LD_BR_STALL  2   stall cycles when an ID branch/jalr reads a load currently in EX (>=2)
//  CNT_W        32  width of performance counters (HAZARD_PERF_EN only)
// PORTS
//  clk            in   1   core clock
//  rst            in   1   synchronous reset, active-high
//  ID_RegRs       in   5   rs1 index of instruction in ID
//  ID_RegRt       in   5   rs2 index of instruction in ID
//  ID_use_rs      in   1   ID instruction reads rs1
//  ID_use_rt      in   1   ID instruction reads rs2
//  branch_or_jalr in   1   ID instruction is a branch or jalr (resolved in ID)
//  ID_taken       in   1   ID branch taken / jalr; redirect valid this cycle
//  EX_RegRd       in   5   destination register of instruction in EX
//  EX_RegWrite    in   1   EX instruction writes a register
//  EX_MemRead     in   1   EX instruction is a load
//  MEM_RegRd      in   5   destination register of instruction in MEM
//  MEM_MemRead    in   1   MEM instruction is a load
//  mem_stall      in   1   IM/DM/DRAM wait; freeze the whole pipe
//  PC_write       out  1   PC update enable
//  IF_ID_write    out  1   IF/ID register enable
//  IF_ID_flush    out  1   load NOP into IF/ID
//  ID_EX_flush    out  1   load bubble into ID/EX
//  hazard_stall   out  1   1 while a hazard hold is active (incl. detect cycle)
//  stall_cycles   out  CNT_W  hazard-stall cycle count (0 without HAZARD_PERF_EN)
//  flush_cycles   out  CNT_W  IF/ID flush count (0 without HAZARD_PERF_EN)
// BEHAVIOUR
//  Hit(X,rd) = use_X && rd!=0 && rd==ID_RegX; evaluated for rs and rt, OR-combined.
//  Required stall N, evaluated only when cnt==0; priority top-down:
//  - branch_or_jalr && EX_MemRead && hit(EX_RegRd)           -> N=LD_BR_STALL
//  - branch_or_jalr && EX_RegWrite && hit(EX_RegRd)          -> N=1
//  - branch_or_jalr && MEM_MemRead && hit(MEM_RegRd)         -> N=1
//  - !branch_or_jalr && EX_MemRead && hit(EX_RegRd)          -> N=1
//  - else                                                     -> N=0
//  State: 2-bit down-counter cnt; RUN when cnt==0, HOLD when cnt!=0.
//  - RUN, N>0, !mem_stall: stall this cycle; cnt<=N-1.
//  - HOLD, !mem_stall: stall; cnt<=cnt-1; no new detection; ID_taken ignored.
//  - Stall cycle: PC_write=0, IF_ID_write=0, ID_EX_flush=1, IF_ID_flush=0, hazard_stall=1.
//  - RUN, N==0: PC_write=1, IF_ID_write=1, ID_EX_flush=0; IF_ID_flush=ID_taken.
//  - mem_stall=1 (overrides all): PC_write=0, IF_ID_write=0, both flushes=0; cnt and counters hold.
//    hazard_stall reflects (cnt!=0 || N>0).
//  Outputs are combinational from cnt and inputs; latency 0 from detection to stall.
//  While rst=1: PC_write=0, IF_ID_write=0, IF_ID_flush=1, ID_EX_flush=1, hazard_stall=0;
//  cnt<=0; counters<=0. Reset mid-hold aborts the hold.
//  Register x0 never triggers a hazard.
// CONFIGURATION
//  HAZARD_PERF_EN defined:
//  - stall_cycles += 1 on each cycle with hazard_stall && !mem_stall.
//  - flush_cycles += 1 on each IF_ID_flush && !rst.
//  - Both counters wrap at 2^CNT_W.
//  HAZARD_PERF_EN undefined: no counter registers; stall_cycles and flush_cycles tied to 0.
// TESTING
//  - lw x5 in EX; ID add uses rs1=x5
//    -> 1 cycle with PC_write=0, ID_EX_flush=1, then PC_write=1.
//  - lw x5 in EX; ID beq uses x5
//    -> 2 consecutive stall cycles (cnt 1->0), PC_write=1 on cycle 3.
//  - add x6 in EX; ID jalr uses rs1=x6
//    -> 1 stall; add x6 in MEM, no load; beq uses x6 -> no stall.
//  - EX_RegRd=0 with EX_MemRead=1, ID uses x0 -> no stall.
//    ID_taken=1 in RUN -> IF_ID_flush=1 for 1 cycle.
//  - mem_stall=1 in 2nd cycle of a 2-cycle load-branch hold
//    -> all enables 0, cnt frozen; hold resumes after mem_stall drops (2 total stall cycles).
//  - rst asserted during HOLD -> next cycle cnt=0, RUN.
//    With HAZARD_PERF_EN: 3 stall cycles + 1 flush -> stall_cycles=3, flush_cycles=1.

Source files
------------

// File: rtl/id_hazard_ctrl.sv
// ID-stage stall/flush controller: load-use and branch operand hazards, taken redirect, memory freeze.
// Optional HAZARD_PERF_EN adds stall/flush performance counters.
module id_hazard_ctrl #(
  parameter int LD_BR_STALL = 2,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       ID_RegRs,
  input  logic [4:0]       ID_RegRt,
  input  logic             ID_use_rs,
  input  logic             ID_use_rt,
  input  logic             branch_or_jalr,
  input  logic             ID_taken,
  input  logic [4:0]       EX_RegRd,
  input  logic             EX_RegWrite,
  input  logic             EX_MemRead,
  input  logic [4:0]       MEM_RegRd,
  input  logic             MEM_MemRead,
  input  logic             mem_stall,
  output logic             PC_write,
  output logic             IF_ID_write,
  output logic             IF_ID_flush,
  output logic             ID_EX_flush,
  output logic             hazard_stall,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_cycles
);

  localparam logic [2:0] LB_N = 3'(LD_BR_STALL);

  logic [1:0] cnt;
  logic [1:0] cnt_nxt;
  logic [2:0] n_req;
  logic       ex_hit;
  logic       mem_hit;
  logic       ex_wr;
  logic       hold;
  logic       stall;

  always_comb begin
    ex_hit  = (ID_use_rs && EX_RegRd != 5'd0 && EX_RegRd == ID_RegRs) ||
              (ID_use_rt && EX_RegRd != 5'd0 && EX_RegRd == ID_RegRt);
    mem_hit = (ID_use_rs && MEM_RegRd != 5'd0 && MEM_RegRd == ID_RegRs) ||
              (ID_use_rt && MEM_RegRd != 5'd0 && MEM_RegRd == ID_RegRt);
    ex_wr   = ex_hit && (EX_MemRead || EX_RegWrite);
  end

  // Arms are made mutually exclusive to encode the top-down priority.
  always_comb begin
    n_req = 3'd0;
    if (cnt == 2'd0) begin
      unique case (1'b1)
        branch_or_jalr && EX_MemRead && ex_hit:
          n_req = LB_N;
        branch_or_jalr && !EX_MemRead && EX_RegWrite && ex_hit:
          n_req = 3'd1;
        branch_or_jalr && !ex_wr && MEM_MemRead && mem_hit:
          n_req = 3'd1;
        !branch_or_jalr && EX_MemRead && ex_hit:
          n_req = 3'd1;
        default:
          n_req = 3'd0;
      endcase
    end
  end

  assign hold  = (cnt != 2'd0);
  assign stall = hold || (n_req != 3'd0);

  always_comb begin
    cnt_nxt = cnt;
    if (!mem_stall) begin
      if (hold)
        cnt_nxt = cnt - 2'd1;
      else if (n_req != 3'd0)
        cnt_nxt = 2'(n_req - 3'd1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      cnt <= 2'd0;
    else
      cnt <= cnt_nxt;
  end

  always_comb begin
    PC_write     = 1'b1;
    IF_ID_write  = 1'b1;
    IF_ID_flush  = ID_taken;
    ID_EX_flush  = 1'b0;
    hazard_stall = stall;
    if (rst) begin
      PC_write     = 1'b0;
      IF_ID_write  = 1'b0;
      IF_ID_flush  = 1'b1;
      ID_EX_flush  = 1'b1;
      hazard_stall = 1'b0;
    end else if (mem_stall) begin
      PC_write    = 1'b0;
      IF_ID_write = 1'b0;
      IF_ID_flush = 1'b0;
      ID_EX_flush = 1'b0;
    end else if (stall) begin
      PC_write    = 1'b0;
      IF_ID_write = 1'b0;
      IF_ID_flush = 1'b0;
      ID_EX_flush = 1'b1;
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_cycles <= '0;
    end else begin
      if (hazard_stall && !mem_stall)
        stall_cycles <= stall_cycles + 1'b1;
      if (IF_ID_flush)
        flush_cycles <= flush_cycles + 1'b1;
    end
  end
`else
  assign stall_cycles = '0;
  assign flush_cycles = '0;
`endif

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Directed-vector bench for id_hazard_ctrl.
// Output vector order: {PC_write, IF_ID_write, IF_ID_flush, ID_EX_flush, hazard_stall}.
module tb_id_hazard_ctrl;

  localparam int CNT_W = 32;

  localparam logic [4:0] O_RUN  = 5'b11000;
  localparam logic [4:0] O_TAKE = 5'b11100;
  localparam logic [4:0] O_STL  = 5'b00011;
  localparam logic [4:0] O_RST  = 5'b00110;
  localparam logic [4:0] O_MSH  = 5'b00001;
  localparam logic [4:0] O_MS   = 5'b00000;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] ID_RegRs, ID_RegRt, EX_RegRd, MEM_RegRd;
  logic ID_use_rs, ID_use_rt, branch_or_jalr, ID_taken;
  logic EX_RegWrite, EX_MemRead, MEM_MemRead, mem_stall;
  logic PC_write, IF_ID_write, IF_ID_flush, ID_EX_flush, hazard_stall;
  logic [CNT_W-1:0] stall_cycles, flush_cycles;
  logic [4:0] o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign o = {PC_write, IF_ID_write, IF_ID_flush, ID_EX_flush, hazard_stall};

  id_hazard_ctrl #(.LD_BR_STALL(2), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .ID_RegRs(ID_RegRs), .ID_RegRt(ID_RegRt),
    .ID_use_rs(ID_use_rs), .ID_use_rt(ID_use_rt),
    .branch_or_jalr(branch_or_jalr), .ID_taken(ID_taken),
    .EX_RegRd(EX_RegRd), .EX_RegWrite(EX_RegWrite),
    .EX_MemRead(EX_MemRead),
    .MEM_RegRd(MEM_RegRd), .MEM_MemRead(MEM_MemRead),
    .mem_stall(mem_stall),
    .PC_write(PC_write), .IF_ID_write(IF_ID_write),
    .IF_ID_flush(IF_ID_flush), .ID_EX_flush(ID_EX_flush),
    .hazard_stall(hazard_stall),
    .stall_cycles(stall_cycles), .flush_cycles(flush_cycles)
  );

  task automatic clear_in();
    ID_RegRs = 5'd0; ID_RegRt = 5'd0;
    ID_use_rs = 1'b0; ID_use_rt = 1'b0;
    branch_or_jalr = 1'b0; ID_taken = 1'b0;
    EX_RegRd = 5'd0; EX_RegWrite = 1'b0; EX_MemRead = 1'b0;
    MEM_RegRd = 5'd0; MEM_MemRead = 1'b0;
    mem_stall = 1'b0;
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic ld_br_x5();
    clear_in();
    branch_or_jalr = 1'b1;
    ID_RegRs = 5'd5; ID_use_rs = 1'b1;
    EX_RegRd = 5'd5; EX_RegWrite = 1'b1; EX_MemRead = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_in();
    ID_taken = 1'b1;
    next_cyc();
    @(negedge clk);
    checks++;
    if (o !== O_RST) begin
      errors++;
      $display("FAIL reset_outs got=%b exp=%b", o, O_RST);
    end
    checks++;
    if (stall_cycles !== '0 || flush_cycles !== '0) begin
      errors++;
      $display("FAIL reset_cnt got=%0d/%0d exp=0/0", stall_cycles, flush_cycles);
    end
    next_cyc();
    rst = 1'b0;
    clear_in();
    @(negedge clk);
    checks++;
    if (o !== O_RUN) begin
      errors++;
      $display("FAIL after_reset got=%b exp=%b", o, O_RUN);
    end
    next_cyc();
  endtask

  task automatic test_load_use();
    clear_in();
    ID_RegRs = 5'd5; ID_use_rs = 1'b1;
    EX_RegRd = 5'd5; EX_RegWrite = 1'b1; EX_MemRead = 1'b1;
    @(negedge clk);
    checks++;
    if (o !== O_STL) begin
      errors++;
      $display("FAIL load_use_stall got=%b exp=%b", o, O_STL);
    end
    next_cyc();
    clear_in();
    ID_RegRs = 5'd5; ID_use_rs = 1'b1;
    MEM_RegRd = 5'd5; MEM_MemRead = 1'b1;
    @(negedge clk);
    checks++;
    if (o !== O_RUN) begin
      errors++;
      $display("FAIL load_use_release got=%b exp=%b", o, O_RUN);
    end
    next_cyc();
    clear_in();
    ID_RegRt = 5'd9; ID_use_rt = 1'b1;
    EX_RegRd = 5'd9; EX_MemRead = 1'b1;
    @(negedge clk);
    checks++;
    if (o !== O_STL) begin
      errors++;
      $display("FAIL load_use_rt got=%b exp=%b", o, O_STL);
    end
    next_cyc();
  endtask

  task automatic test_load_branch();
    ld_br_x5();
    @(negedge clk);
    checks++;
    if (o !== O_STL) begin
      errors++;
      $display("FAIL ldbr_c1 got=%b exp=%b", o, O_STL);
    end
    next_cyc();
    clear_in();
    branch_or_jalr = 1'b1; ID_taken = 1'b1;
    ID_RegRs = 5'd5; ID_use_rs = 1'b1;
    MEM_RegRd = 5'd5; MEM_MemRead = 1'b1;
    @(negedge clk);
    checks++;
    if (o !== O_STL) begin
      errors++;
      $display("FAIL ldbr_c2 got=%b exp=%b", o, O_STL);
    end
    next_cyc();
    clear_in();
    branch_or_jalr = 1'b1;
    ID_RegRs = 5'd5; ID_use_rs = 1'b1;
    @(negedge clk);
    checks++;
    if (o !== O_RUN) begin
      errors++;
      $display("FAIL ldbr_c3 got=%b exp=%b", o, O_RUN);
    end
    next_cyc();
  endtask

  task automatic test_alu_jalr();
    clear_in();
    branch_or_jalr = 1'b1;
    ID_RegRs = 5'd6; ID_use_rs = 1'b1;
    EX_RegRd = 5'd6; EX_RegWrite = 1'b1;
    @(negedge clk);
    checks++;
    if (o !== O_STL) begin
      errors++;
      $display("FAIL alu_jalr_stall got=%b exp=%b", o, O_STL);
    end
    next_cyc();
    clear_in();
    branch_or_jalr = 1'b1;
    ID_RegRs = 5'd6; ID_use_rs = 1'b1;
    MEM_RegRd = 5'd6;
    @(negedge clk);
    checks++;
    if (o !== O_RUN) begin
      errors++;
      $display("FAIL alu_mem_nostall got=%b exp=%b", o, O_RUN);
    end
    next_cyc();
    clear_in();
    branch_or_jalr = 1'b1;
    ID_RegRt = 5'd7; ID_use_rt = 1'b1;
    MEM_RegRd = 5'd7; MEM_MemRead = 1'b1;
    @(negedge clk);
    checks++;
    if (o !== O_STL) begin
      errors++;
      $display("FAIL br_mem_load got=%b exp=%b", o, O_STL);
    end
    next_cyc();
    clear_in();
    @(negedge clk);
    checks++;
    if (o !== O_RUN) begin
      errors++;
      $display("FAIL br_mem_release got=%b exp=%b", o, O_RUN);
    end
    next_cyc();
  endtask

  task automatic test_x0_and_taken();
    clear_in();
    ID_RegRs = 5'd0; ID_use_rs = 1'b1;
    EX_RegRd = 5'd0; EX_MemRead = 1'b1; EX_RegWrite = 1'b1;
    @(negedge clk);
    checks++;
    if (o !== O_RUN) begin
      errors++;
      $display("FAIL x0_nostall got=%b exp=%b", o, O_RUN);
    end
    next_cyc();
    clear_in();
    ID_RegRt = 5'd8; ID_use_rt = 1'b0;
    EX_RegRd = 5'd8; EX_MemRead = 1'b1;
    @(negedge clk);
    checks++;
    if (o !== O_RUN) begin
      errors++;
      $display("FAIL unused_rt got=%b exp=%b", o, O_RUN);
    end
    next_cyc();
    clear_in();
    branch_or_jalr = 1'b1; ID_taken = 1'b1;
    @(negedge clk);
    checks++;
    if (o !== O_TAKE) begin
      errors++;
      $display("FAIL taken_flush got=%b exp=%b", o, O_TAKE);
    end
    next_cyc();
    clear_in();
    @(negedge clk);
    checks++;
    if (o !== O_RUN) begin
      errors++;
      $display("FAIL taken_after got=%b exp=%b", o, O_RUN);
    end
    next_cyc();
  endtask

  task automatic test_mem_stall();
    ld_br_x5();
    @(negedge clk);
    checks++;
    if (o !== O_STL) begin
      errors++;
      $display("FAIL ms_c1 got=%b exp=%b", o, O_STL);
    end
    next_cyc();
    clear_in();
    mem_stall = 1'b1; ID_taken = 1'b1;
    @(negedge clk);
    checks++;
    if (o !== O_MSH) begin
      errors++;
      $display("FAIL ms_frozen got=%b exp=%b", o, O_MSH);
    end
    next_cyc();
    clear_in();
    @(negedge clk);
    checks++;
    if (o !== O_STL) begin
      errors++;
      $display("FAIL ms_resume got=%b exp=%b", o, O_STL);
    end
    next_cyc();
    clear_in();
    @(negedge clk);
    checks++;
    if (o !== O_RUN) begin
      errors++;
      $display("FAIL ms_release got=%b exp=%b", o, O_RUN);
    end
    next_cyc();
    clear_in();
    mem_stall = 1'b1;
    @(negedge clk);
    checks++;
    if (o !== O_MS) begin
      errors++;
      $display("FAIL ms_idle got=%b exp=%b", o, O_MS);
    end
    next_cyc();
  endtask

  task automatic test_reset_hold();
    ld_br_x5();
    next_cyc();
    clear_in();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (o !== O_RST) begin
      errors++;
      $display("FAIL rst_hold got=%b exp=%b", o, O_RST);
    end
    next_cyc();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (o !== O_RUN) begin
      errors++;
      $display("FAIL rst_abort got=%b exp=%b", o, O_RUN);
    end
    next_cyc();
  endtask

  task automatic test_perf();
    logic [CNT_W-1:0] exp_s;
    logic [CNT_W-1:0] exp_f;
`ifdef HAZARD_PERF_EN
    exp_s = 3;
    exp_f = 1;
`else
    exp_s = 0;
    exp_f = 0;
`endif
    clear_in();
    rst = 1'b1;
    next_cyc();
    rst = 1'b0;
    ld_br_x5();
    next_cyc();
    clear_in();
    next_cyc();
    clear_in();
    EX_RegRd = 5'd3; EX_MemRead = 1'b1;
    ID_RegRs = 5'd3; ID_use_rs = 1'b1;
    mem_stall = 1'b1;
    next_cyc();
    mem_stall = 1'b0;
    next_cyc();
    clear_in();
    ID_taken = 1'b1;
    next_cyc();
    clear_in();
    @(negedge clk);
    checks++;
    if (stall_cycles !== exp_s) begin
      errors++;
      $display("FAIL perf_stall got=%0d exp=%0d", stall_cycles, exp_s);
    end
    checks++;
    if (flush_cycles !== exp_f) begin
      errors++;
      $display("FAIL perf_flush got=%0d exp=%0d", flush_cycles, exp_f);
    end
    next_cyc();
  endtask

  initial begin
    rst = 1'b1;
    clear_in();
    test_reset();
    test_load_use();
    test_load_branch();
    test_alu_jalr();
    test_x0_and_taken();
    test_mem_stall();
    test_reset_hold();
    test_perf();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
